// File: rtl/fn_sw_pkg.sv
// Shared types for the function-switch deserializer: assembly state,
// default word width and the word record handed to the output register.
package fn_sw_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int MAX_WIDTH = 32;
    localparam int MAX_CNT_W = 6;   // $clog2(MAX_WIDTH + 1)

    // EMPTY: no bits held; FILLING: partial word; FULL: complete word
    // parked because the output register is still occupied.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } asm_state_e;

    // Sized for the widest legal word; narrower instances zero the top bits.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] data;
        logic [MAX_CNT_W-1:0] len;
        logic [MAX_CNT_W-1:0] ones;
        logic                 op;
        logic                 mixed;
    } word_t;

endpackage

// File: rtl/fn_sw_deser_if.sv
// Bit-side and word-side signals of the deserializer.
//
// Handshake rule (both sides): a transfer happens on the rising clk edge
// where valid and ready are both 1. A source keeps valid and its payload
// stable until that edge; ready may depend combinationally on state but
// never on the same-cycle valid.
interface fn_sw_deser_if #(
    parameter int WIDTH = fn_sw_pkg::DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             bit_vld;
    logic             bit_in;
    logic             sel_in;
    logic             bit_rdy;
    logic             flush;
    logic             word_vld;
    logic             word_rdy;
    logic [WIDTH-1:0] word_data;
    logic [CNT_W-1:0] word_len;
    logic [CNT_W-1:0] word_ones;
    logic             word_op;
    logic             word_mixed;

    // Deserializer side.
    modport slave (
        input  bit_vld, bit_in, sel_in, flush, word_rdy,
        output bit_rdy, word_vld, word_data, word_len, word_ones, word_op, word_mixed
    );

    // Producer/consumer side.
    modport master (
        output bit_vld, bit_in, sel_in, flush, word_rdy,
        input  bit_rdy, word_vld, word_data, word_len, word_ones, word_op, word_mixed
    );
endinterface

// File: rtl/fn_sw_word_reg.sv
// Output holding register: one word with valid/ready. It accepts a new
// word whenever it is empty or its current word leaves on this edge.
module fn_sw_word_reg
    import fn_sw_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  word_t load_word,
    input  logic  rdy,
    output logic  vld,
    output word_t word,
    output logic  load_ok
);

    // Free slot this cycle: empty, or being drained at this edge.
    assign load_ok = !vld || rdy;

    // Hold the word until the consumer takes it; reload in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            word <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            word <= load_word;
        end else if (rdy) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/fn_sw_deser.sv
// Collects the switch's serial result bits into WIDTH-bit words, tagging
// each with its length, ones count, first-bit sel and a mixed-sel flag.
// An assembly register feeds an output register so bit collection keeps
// going while a finished word waits for the consumer.
module fn_sw_deser
    import fn_sw_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    fn_sw_deser_if.slave        bus,
    output asm_state_e          asm_state
);

    asm_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic             op_q, op_d;
    logic             mixed_q, mixed_d;

    // Word as it stands after this cycle's bit (if any) is folded in.
    logic             accept;
    logic [WIDTH-1:0] w_data;
    logic [CNT_W-1:0] w_len;
    logic [CNT_W-1:0] w_ones;
    logic             w_op;
    logic             w_mixed;
    logic             complete;

    logic             load;
    logic             load_ok;
    word_t            load_word;
    word_t            out_word;
    logic             out_vld;
    logic             unused_out;

    assign bus.bit_rdy = (state_q != FULL);
    assign asm_state   = state_q;

    // Fold the incoming bit into the assembly word and decide the next state.
    always_comb begin
        accept  = bus.bit_vld && (state_q != FULL);
        w_data  = data_q | (WIDTH'(accept && bus.bit_in) << idx_q);
        w_len   = idx_q + CNT_W'(accept);
        w_ones  = ones_q + CNT_W'(accept && bus.bit_in);
        w_op    = op_q;
        w_mixed = mixed_q;
        if (accept) begin
            if (idx_q == '0) begin
                w_op    = bus.sel_in;
                w_mixed = 1'b0;
            end else begin
                w_mixed = mixed_q | (bus.sel_in != op_q);
            end
        end

        // FULL is already complete, so a flush there changes nothing.
        complete = (state_q == FULL) || (w_len == CNT_W'(WIDTH)) ||
                   (bus.flush && (w_len != '0));
        load     = complete && load_ok;

        state_d = state_q;
        data_d  = w_data;
        idx_d   = w_len;
        ones_d  = w_ones;
        op_d    = w_op;
        mixed_d = w_mixed;
        if (load) begin
            state_d = EMPTY;
            data_d  = '0;
            idx_d   = '0;
            ones_d  = '0;
            op_d    = 1'b0;
            mixed_d = 1'b0;
        end else if (complete) begin
            state_d = FULL;
        end else if (w_len != '0) begin
            state_d = FILLING;
        end else begin
            state_d = EMPTY;
        end
    end

    // Assembly state and word-in-progress registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            idx_q   <= '0;
            ones_q  <= '0;
            op_q    <= 1'b0;
            mixed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            op_q    <= op_d;
            mixed_q <= mixed_d;
        end
    end

    // Widen the completed word into the shared record layout.
    always_comb begin
        load_word                  = '0;
        load_word.data[WIDTH-1:0]  = w_data;
        load_word.len[CNT_W-1:0]   = w_len;
        load_word.ones[CNT_W-1:0]  = w_ones;
        load_word.op               = w_op;
        load_word.mixed            = w_mixed;
    end

    fn_sw_word_reg u_word_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (load_word),
        .rdy       (bus.word_rdy),
        .vld       (out_vld),
        .word      (out_word),
        .load_ok   (load_ok)
    );

    assign bus.word_vld   = out_vld;
    assign bus.word_data  = out_word.data[WIDTH-1:0];
    assign bus.word_len   = out_word.len[CNT_W-1:0];
    assign bus.word_ones  = out_word.ones[CNT_W-1:0];
    assign bus.word_op    = out_word.op;
    assign bus.word_mixed = out_word.mixed;

    // Padding bits above WIDTH/CNT_W are always zero.
    assign unused_out = ^out_word;

endmodule

// File: tb/tb_fn_sw_deser.sv
// Directed bench for fn_sw_deser at WIDTH=8. Inputs change on the falling
// edge; outputs are sampled on the falling edge before new inputs go on.
module tb_fn_sw_deser;
    import fn_sw_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    asm_state_e asm_state;
    int         checks = 0;
    int         errors = 0;
    logic [13:0] exp_q[$];   // {mixed, op, ones, data}

    fn_sw_deser_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    fn_sw_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .asm_state (asm_state)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Drivers.
    task automatic drive_bit(input logic b, input logic s, input logic fl);
        @(negedge clk);
        bus.bit_vld = 1'b1;
        bus.bit_in  = b;
        bus.sel_in  = s;
        bus.flush   = fl;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.bit_vld = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic test_reset();
        bus.bit_vld  = 1'b0;
        bus.bit_in   = 1'b0;
        bus.sel_in   = 1'b0;
        bus.flush    = 1'b0;
        bus.word_rdy = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.bit_rdy !== 1'b1) begin errors++; $display("FAIL reset_bit_rdy got %0b exp 1", bus.bit_rdy); end
        checks++; if (bus.word_vld !== 1'b0) begin errors++; $display("FAIL reset_word_vld got %0b exp 0", bus.word_vld); end
        checks++; if (bus.word_data !== 8'h00) begin errors++; $display("FAIL reset_word_data got %h exp 00", bus.word_data); end
        checks++; if (bus.word_len !== 4'd0) begin errors++; $display("FAIL reset_word_len got %0d exp 0", bus.word_len); end
        checks++; if (bus.word_ones !== 4'd0) begin errors++; $display("FAIL reset_word_ones got %0d exp 0", bus.word_ones); end
        checks++; if (bus.word_op !== 1'b0 || bus.word_mixed !== 1'b0) begin errors++; $display("FAIL reset_op_mixed got %0b%0b exp 00", bus.word_op, bus.word_mixed); end
        checks++; if (asm_state !== EMPTY) begin errors++; $display("FAIL reset_state got %0d exp 0", asm_state); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'h8D;
        bus.word_rdy = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(pat[i], 1'b1, 1'b0);
        drive_idle();
        checks++; if (bus.word_vld !== 1'b1) begin errors++; $display("FAIL basic_vld got %0b exp 1", bus.word_vld); end
        checks++; if (bus.word_data !== 8'h8D) begin errors++; $display("FAIL basic_data got %h exp 8d", bus.word_data); end
        checks++; if (bus.word_len !== 4'd8 || bus.word_ones !== 4'd4) begin errors++; $display("FAIL basic_len_ones got %0d/%0d exp 8/4", bus.word_len, bus.word_ones); end
        checks++; if (bus.word_op !== 1'b1 || bus.word_mixed !== 1'b0) begin errors++; $display("FAIL basic_op_mixed got %0b%0b exp 10", bus.word_op, bus.word_mixed); end
        drive_idle();
        checks++; if (bus.word_vld !== 1'b0) begin errors++; $display("FAIL basic_drained got %0b exp 0", bus.word_vld); end
    endtask

    task automatic test_mixed();
        bus.word_rdy = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(1'b1, (i >= 4), 1'b0);
        drive_idle();
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'hFF) begin errors++; $display("FAIL mixed_data got vld=%0b %h exp vld=1 ff", bus.word_vld, bus.word_data); end
        checks++; if (bus.word_ones !== 4'd8) begin errors++; $display("FAIL mixed_ones got %0d exp 8", bus.word_ones); end
        checks++; if (bus.word_op !== 1'b0 || bus.word_mixed !== 1'b1) begin errors++; $display("FAIL mixed_op_mixed got %0b%0b exp 01", bus.word_op, bus.word_mixed); end
        drive_idle();
    endtask

    task automatic test_backpressure();
        logic [7:0] w1;
        logic [7:0] w2;
        w1 = 8'h5A;
        w2 = 8'hC3;
        bus.word_rdy = 1'b0;
        for (int i = 0; i < 8; i++) drive_bit(w1[i], 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w2[i], 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0);
        checks++; if (bus.bit_rdy !== 1'b0 || asm_state !== FULL) begin errors++; $display("FAIL bp_stall got rdy=%0b st=%0d exp rdy=0 st=2", bus.bit_rdy, asm_state); end
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'h5A || bus.word_op !== 1'b0) begin errors++; $display("FAIL bp_word1 got vld=%0b %h op=%0b exp vld=1 5a op=0", bus.word_vld, bus.word_data, bus.word_op); end
        drive_bit(1'b1, 1'b1, 1'b0);
        checks++; if (bus.bit_rdy !== 1'b0 || bus.word_data !== 8'h5A || bus.word_len !== 4'd8) begin errors++; $display("FAIL bp_hold got rdy=%0b %h len=%0d exp rdy=0 5a len=8", bus.bit_rdy, bus.word_data, bus.word_len); end
        bus.word_rdy = 1'b1;
        @(negedge clk);
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'hC3) begin errors++; $display("FAIL bp_word2 got vld=%0b %h exp vld=1 c3", bus.word_vld, bus.word_data); end
        checks++; if (bus.word_ones !== 4'd4 || bus.word_op !== 1'b1 || bus.word_mixed !== 1'b0) begin errors++; $display("FAIL bp_word2_tags got ones=%0d op=%0b mx=%0b exp 4 1 0", bus.word_ones, bus.word_op, bus.word_mixed); end
        checks++; if (bus.bit_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_back got %0b exp 1", bus.bit_rdy); end
        bus.word_rdy = 1'b0;
        bus.bit_vld  = 1'b0;
        drive_idle();
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'hC3) begin errors++; $display("FAIL bp_word2_hold got vld=%0b %h exp vld=1 c3", bus.word_vld, bus.word_data); end
        bus.word_rdy = 1'b1;
        drive_idle();
        checks++; if (bus.word_vld !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b exp 0", bus.word_vld); end
    endtask

    task automatic test_flush();
        logic [7:0] pat;
        bus.word_rdy = 1'b1;
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.bit_vld = 1'b0;
        bus.flush   = 1'b1;
        drive_idle();
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'h03) begin errors++; $display("FAIL flush3_data got vld=%0b %h exp vld=1 03", bus.word_vld, bus.word_data); end
        checks++; if (bus.word_len !== 4'd3 || bus.word_ones !== 4'd2) begin errors++; $display("FAIL flush3_len_ones got %0d/%0d exp 3/2", bus.word_len, bus.word_ones); end
        drive_idle();
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b1);
        drive_idle();
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'h0B) begin errors++; $display("FAIL flush4_data got vld=%0b %h exp vld=1 0b", bus.word_vld, bus.word_data); end
        checks++; if (bus.word_len !== 4'd4 || bus.word_ones !== 4'd3) begin errors++; $display("FAIL flush4_len_ones got %0d/%0d exp 4/3", bus.word_len, bus.word_ones); end
        drive_idle();
        // Flush with nothing assembled.
        @(negedge clk);
        bus.flush = 1'b1;
        drive_idle();
        checks++; if (bus.word_vld !== 1'b0) begin errors++; $display("FAIL flush_empty got %0b exp 0", bus.word_vld); end
        drive_idle();
        checks++; if (bus.word_vld !== 1'b0 || asm_state !== EMPTY) begin errors++; $display("FAIL flush_empty2 got vld=%0b st=%0d exp 0 0", bus.word_vld, asm_state); end
        // Eighth bit together with flush gives exactly one word.
        pat = 8'hF0;
        for (int i = 0; i < 8; i++) drive_bit(pat[i], 1'b1, (i == 7));
        drive_idle();
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'hF0 || bus.word_len !== 4'd8) begin errors++; $display("FAIL flush8_word got vld=%0b %h len=%0d exp 1 f0 8", bus.word_vld, bus.word_data, bus.word_len); end
        drive_idle();
        checks++; if (bus.word_vld !== 1'b0) begin errors++; $display("FAIL flush8_single got %0b exp 0", bus.word_vld); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pat;
        bus.word_rdy = 1'b0;
        for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        bus.bit_vld = 1'b0;
        checks++; if (bus.word_vld !== 1'b1) begin errors++; $display("FAIL rmid_pre_vld got %0b exp 1", bus.word_vld); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.word_vld !== 1'b0 || bus.word_data !== 8'h00) begin errors++; $display("FAIL rmid_async got vld=%0b %h exp 0 00", bus.word_vld, bus.word_data); end
        checks++; if (bus.bit_rdy !== 1'b1 || bus.word_len !== 4'd0 || bus.word_ones !== 4'd0 || asm_state !== EMPTY) begin errors++; $display("FAIL rmid_fields got rdy=%0b len=%0d ones=%0d st=%0d exp 1 0 0 0", bus.bit_rdy, bus.word_len, bus.word_ones, asm_state); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.word_rdy = 1'b1;
        pat = 8'h81;
        for (int i = 0; i < 8; i++) drive_bit(pat[i], 1'b1, 1'b0);
        drive_idle();
        checks++; if (bus.word_vld !== 1'b1 || bus.word_data !== 8'h81) begin errors++; $display("FAIL rmid_clean got vld=%0b %h exp 1 81", bus.word_vld, bus.word_data); end
        checks++; if (bus.word_len !== 4'd8 || bus.word_ones !== 4'd2 || bus.word_op !== 1'b1 || bus.word_mixed !== 1'b0) begin errors++; $display("FAIL rmid_tags got len=%0d ones=%0d op=%0b mx=%0b exp 8 2 1 0", bus.word_len, bus.word_ones, bus.word_op, bus.word_mixed); end
        drive_idle();
    endtask

    task automatic test_streaming();
        logic [7:0]  bits_v;
        logic [7:0]  sels_v;
        logic [13:0] exp_w;
        logic [13:0] got_w;
        logic [3:0]  n_ones;
        logic        b;
        logic        s;
        logic        mx;
        int          words_seen;
        words_seen = 0;
        bits_v = '0;
        sels_v = '0;
        exp_q.delete();
        bus.word_rdy = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            @(negedge clk);
            checks++; if (bus.bit_rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy cycle %0d got %0b exp 1", i, bus.bit_rdy); end
            checks++; if (bus.word_vld !== ((i > 0) && (i % 8 == 0))) begin errors++; $display("FAIL stream_vld_timing cycle %0d got %0b", i, bus.word_vld); end
            if (bus.word_vld === 1'b1) begin
                words_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_word got %h exp none", bus.word_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    got_w = {bus.word_mixed, bus.word_op, bus.word_ones, bus.word_data};
                    if (got_w !== exp_w || bus.word_len !== 4'd8) begin
                        errors++; $display("FAIL stream_word got %h len=%0d exp %h len=8", got_w, bus.word_len, exp_w);
                    end
                end
            end
            if (i < 64) begin
                b = 1'($urandom_range(0, 1));
                s = ((i / 8) % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'((i / 16) % 2);
                bus.bit_vld = 1'b1;
                bus.bit_in  = b;
                bus.sel_in  = s;
                bus.flush   = 1'b0;
                bits_v[i % 8] = b;
                sels_v[i % 8] = s;
                if (i % 8 == 7) begin
                    n_ones = 4'($countones(bits_v));
                    mx     = (sels_v != 8'h00) && (sels_v != 8'hFF);
                    exp_q.push_back({mx, sels_v[0], n_ones, bits_v});
                end
            end else begin
                bus.bit_vld = 1'b0;
            end
        end
        checks++; if (words_seen != 8) begin errors++; $display("FAIL stream_word_count got %0d exp 8", words_seen); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_leftover got %0d exp 0", exp_q.size()); end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_streaming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fn_sw_deser.md
Name: fn_sw_deser

Overview:
- Downstream stage of the a/b/sel function switch: collects its serial 1-bit result y, with the sel tag active for each bit, into WIDTH-bit words.
- Delivers each word over a valid/ready handshake, along with:
  - its population count,
  - its valid-bit length,
  - operation tag and mixed-operation flag.
- Two-deep buffering (assembly register + output register) lets bit collection continue while a finished word waits for the consumer.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the ones-count and length fields.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset; assert asynchronously, release synchronously to clk
- bit_vld  in  1  a result bit is presented
- bit_in  in  1  result bit (the switch output y)
- sel_in  in  1  sel value that produced bit_in
- bit_rdy  out  1  block can accept a bit this cycle
- flush  in  1  emit the partial word now
- word_vld  out  1  output word valid
- word_rdy  in  1  consumer accepts the word
- word_data  out  WIDTH  assembled word; first accepted bit in bit 0
- word_len  out  CNT_W  number of valid bits (WIDTH, or fewer after a flush)
- word_ones  out  CNT_W  count of 1s in word_data
- word_op  out  1  sel of the word's first bit
- word_mixed  out  1  sel changed within the word

Behaviour:
- Reset values: bit_rdy=1, word_vld=0, word_data=0, word_len=0, word_ones=0, word_op=0, word_mixed=0. The assembly bit index, ones counter and all state return to zero; a partial word is discarded. Reset mid-word or while a word is held drops that data, and word_vld deasserts immediately.
- Bit accept: bit_vld && bit_rdy at a rising clk edge. The bit is written to assembly position idx; idx increments; the assembly ones count adds bit_in.
  - On the first bit of a word (idx==0): op is latched from sel_in and mixed is cleared.
  - On later bits: mixed |= (sel_in != op).
- Assembly FSM states:
  - EMPTY (idx==0)
  - FILLING (0<idx<WIDTH)
  - FULL (word complete, waiting for the output register).
- Transfer: when the assembly register is complete (WIDTH bits, or flushed with idx>0), it moves to the output register if the output register is empty or is being drained this cycle (word_vld && word_rdy).
  - The WIDTH-th bit accepted at edge N gives word_vld=1 after edge N, with one cycle latency when the output is free.
  - After a transfer, assembly returns to EMPTY with idx=0.
- Stall: if the word completes while the output register is still held, assembly goes to FULL and bit_rdy=0.
  - bit_rdy is combinational: 0 only in FULL.
  - When word_rdy drains the output, FULL transfers at that same edge, and bit_rdy returns to 1 the following cycle.
- Output handshake: word_data/len/ones/op/mixed stay stable while word_vld && !word_rdy. A transfer coinciding with a drain gives back-to-back words with no bubble.
- Flush:
  - Sampled every cycle.
  - With idx>0, marks the partial word complete. Unused high bits are 0 and word_len=idx.
  - If a bit is accepted in the same cycle, that bit is included (len=idx+1). A WIDTH-th bit plus flush produces a single word.
  - Flush with idx==0 and no bit accepted has no effect.
  - Flush while in FULL is ignored.
- Arithmetic: ones count saturation is impossible (max WIDTH fits in CNT_W). idx wraps to 0 only via transfer.
- No bit is ever lost or duplicated. Words leave in arrival order.

Decomposition:
- Shared package fn_sw_pkg:
  - assembly-state enum (EMPTY/FILLING/FULL),
  - default WIDTH constant,
  - output word struct {data, len, ones, op, mixed}.
- One natural sub-module: fn_sw_word_reg, the output holding register with valid/ready and the load-when-empty-or-draining rule. The assembly FSM stays in the top.

Test Plan:
- Basic word: 8 bits 1,0,1,1,0,0,0,1 with sel=1 and word_rdy=1 -> one cycle after the 8th bit, word_data=0x8D, word_len=8, word_ones=4, word_op=1, word_mixed=0.
- Mixed op: sel=0 for bits 0-3, sel=1 for bits 4-7, all bits 1 -> word_data=0xFF, word_ones=8, word_op=0, word_mixed=1.
- Backpressure: word_rdy=0, stream 16 bits -> the first word is held stable; after bit 16 bit_rdy=0 and bit_vld is ignored. Raise word_rdy for one cycle -> word 2 loads at that edge and bit_rdy=1 the next cycle. Both words are correct and in order.
- Flush: 3 bits 1,1,0 then flush alone -> word_data=0x03, word_len=3, word_ones=2. Flush together with a 4th bit=1 instead -> word_data=0x0B, word_len=4. Flush when empty -> no word_vld.
- Reset mid-operation: accept 5 bits, assert rst_n=0 asynchronously between edges -> outputs at reset values immediately. After release, 8 new bits produce a clean word with no stale bits.
- Continuous streaming: bit_vld=1 and word_rdy=1 for 64 cycles with random bits -> 8 words, one every 8 cycles, with no bit_rdy deassertion. Compare each word against a reference packing model.
